// File: rtl/point_sequencer.sv
// point_sequencer: holds position/velocity for every mass point and, on each
// frame tick, walks them one at a time through update_point, writing the
// results back. Also has a load port and a registered read port.
module point_sequencer #(
    parameter int NUM_POINTS        = 8,
    parameter int POSITION_SIZE     = 8,
    parameter int VELOCITY_SIZE     = 8,
    parameter int ACCELERATION_SIZE = 8,
    parameter int TIMEOUT           = 1023
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  frame_start_in,
    input  logic [ACCELERATION_SIZE-1:0]          accel_x_in,
    input  logic [ACCELERATION_SIZE-1:0]          accel_y_in,
    input  logic                                  load_valid_in,
    input  logic [$clog2(NUM_POINTS)-1:0]         load_idx_in,
    input  logic [POSITION_SIZE-1:0]              load_pos_x_in,
    input  logic [POSITION_SIZE-1:0]              load_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0]              load_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0]              load_vel_y_in,
    output logic                                  begin_out,
    output logic [POSITION_SIZE-1:0]              pos_x_out,
    output logic [POSITION_SIZE-1:0]              pos_y_out,
    output logic [VELOCITY_SIZE-1:0]              vel_x_out,
    output logic [VELOCITY_SIZE-1:0]              vel_y_out,
    output logic [ACCELERATION_SIZE-1:0]          accel_x_out,
    output logic [ACCELERATION_SIZE-1:0]          accel_y_out,
    input  logic                                  result_in,
    input  logic [POSITION_SIZE-1:0]              new_pos_x_in,
    input  logic [POSITION_SIZE-1:0]              new_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0]              new_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0]              new_vel_y_in,
    input  logic [$clog2(NUM_POINTS)-1:0]         rd_idx_in,
    output logic [POSITION_SIZE-1:0]              rd_pos_x_out,
    output logic [POSITION_SIZE-1:0]              rd_pos_y_out,
    output logic                                  busy_out,
    output logic                                  frame_done_out,
    output logic                                  timeout_err_out
);
    localparam int IW = $clog2(NUM_POINTS);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW:0]   NP_LIM  = (IW+1)'(NUM_POINTS);
    localparam logic [IW-1:0] LAST    = IW'(NUM_POINTS - 1);
    localparam logic [CW:0]   TMO_LIM = (CW+1)'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;
    state_t state, state_nxt;

    logic [POSITION_SIZE-1:0] reg_px [NUM_POINTS];
    logic [POSITION_SIZE-1:0] reg_py [NUM_POINTS];
    logic [VELOCITY_SIZE-1:0] reg_vx [NUM_POINTS];
    logic [VELOCITY_SIZE-1:0] reg_vy [NUM_POINTS];

    logic [IW-1:0]              idx;
    logic                       armed;
    logic [CW-1:0]              cnt;
    logic [ACCELERATION_SIZE-1:0] acc_x, acc_y;
    logic                       err;
    logic                       capture, tmo_hit, cnt_hit, load_ok, rd_ok;

    // Out-of-range indices only exist when NUM_POINTS is not a power of two.
    assign load_ok = ({1'b0, load_idx_in} < NP_LIM);
    assign rd_ok   = ({1'b0, rd_idx_in} < NP_LIM);
    assign cnt_hit = (({1'b0, cnt} + 1'b1) == TMO_LIM);

    // Operands come straight from the file: entry[idx] cannot change between
    // ISSUE and leaving WAIT, since loads are blocked and write-back happens
    // on the WAIT exit edge.
    assign pos_x_out       = reg_px[idx];
    assign pos_y_out       = reg_py[idx];
    assign vel_x_out       = reg_vx[idx];
    assign vel_y_out       = reg_vy[idx];
    assign accel_x_out     = acc_x;
    assign accel_y_out     = acc_y;
    assign timeout_err_out = err;

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt      = state;
        begin_out      = 1'b0;
        busy_out       = 1'b1;
        frame_done_out = 1'b0;
        capture        = 1'b0;
        tmo_hit        = 1'b0;
        case (state)
            IDLE: begin
                busy_out = 1'b0;
                if (frame_start_in) state_nxt = ISSUE;
            end
            ISSUE: begin
                begin_out = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A result level seen before any low cycle is left over from
                // the previous point and must not be captured.
                if (result_in && armed) begin
                    capture   = 1'b1;
                    state_nxt = NEXT;
                end else if (cnt_hit) begin
                    tmo_hit   = 1'b1;
                    state_nxt = NEXT;
                end
            end
            NEXT: state_nxt = (idx == LAST) ? DONE : ISSUE;
            DONE: begin
                frame_done_out = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register file, point index, arm/timeout tracking and frame acceleration.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                reg_px[i] <= '0;
                reg_py[i] <= '0;
                reg_vx[i] <= '0;
                reg_vy[i] <= '0;
            end
            idx   <= '0;
            armed <= 1'b0;
            cnt   <= '0;
            acc_x <= '0;
            acc_y <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid_in && load_ok) begin
                        reg_px[load_idx_in] <= load_pos_x_in;
                        reg_py[load_idx_in] <= load_pos_y_in;
                        reg_vx[load_idx_in] <= load_vel_x_in;
                        reg_vy[load_idx_in] <= load_vel_y_in;
                    end
                    if (frame_start_in) begin
                        acc_x <= accel_x_in;
                        acc_y <= accel_y_in;
                        idx   <= '0;
                    end
                end
                ISSUE: begin
                    armed <= 1'b0;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (capture) begin
                        reg_px[idx] <= new_pos_x_in;
                        reg_py[idx] <= new_pos_y_in;
                        reg_vx[idx] <= new_vel_x_in;
                        reg_vy[idx] <= new_vel_y_in;
                    end else if (tmo_hit) begin
                        err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (!result_in) armed <= 1'b1;
                    end
                end
                NEXT: if (idx != LAST) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Registered read port; a same-cycle write returns the pre-write value.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_pos_x_out <= '0;
            rd_pos_y_out <= '0;
        end else begin
            rd_pos_x_out <= rd_ok ? reg_px[rd_idx_in] : '0;
            rd_pos_y_out <= rd_ok ? reg_py[rd_idx_in] : '0;
        end
    end
endmodule
